frame_buffer_swapper: RTL and testbench

//  Double-buffered framebuffer downstream of the drawing manager. Holds two pixel banks:
//  the back bank takes the drawing manager's write port, the front bank is read by the
//  VGA scan-out. Starts drawing after reset, swaps banks on the first vblank rising edge

---
 rtl/frame_buffer_swapper_pkg.sv | 25 ++
 rtl/frame_buffer_swapper_bank_ram.sv | 37 +++
 rtl/frame_buffer_swapper.sv | 204 ++++++++++++++++++++
 tb/tb_frame_buffer_swapper.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_swapper_pkg.sv
// Shared types and geometry for the double-buffered framebuffer.
// The VGA reader imports the same package so that its address generator and
// the swapper agree on the frame size.
//   FB_PIXELS  - pixels per frame
//   fb_state_t - swapper sequencing states
package frame_buffer_swapper_pkg;

    localparam int FB_WIDTH     = 160;
    localparam int FB_HEIGHT    = 120;
    localparam int FB_DATA_W    = 12;
    localparam int FB_PIXELS    = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W    = $clog2(FB_PIXELS);
    localparam int FB_MISS_W    = 16;
    localparam int FB_FRAME_W   = 16;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        START    = 3'd1,
        DRAWING  = 3'd2,
        WAIT_VBL = 3'd3,
        SWAP     = 3'd4,
        ACK_WAIT = 3'd5
    } fb_state_t;

endpackage

// File: rtl/frame_buffer_swapper_bank_ram.sv
// One pixel bank: simple dual-port RAM, one write port and one registered
// read port, written so synthesis maps it onto block RAM.
// Contents are never reset.
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_addr  in  write address (caller guarantees it is in range)
//   wr_data  in  write pixel
//   rd_addr  in  read address (caller guarantees it is in range)
//   rd_data  out pixel at rd_addr, one cycle later
module fb_bank_ram #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 15,
    parameter int DEPTH      = 19200
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // No reset here: a reset term on the array or read register would stop
    // block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/frame_buffer_swapper.sv
// Double-buffered framebuffer between the drawing manager and VGA scan-out.
// The back bank (~front_sel) takes drawer writes, the front bank feeds the
// scan-out. A finished frame is swapped in on the next vblank rising edge so
// the display never tears, then the drawer is acked to start the next one.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   fb_write_en/addr/data drawer pixel write port
//   frame_done           drawer holds this high while waiting for draw_ack
//   draw_start           1-cycle pulse: draw the first frame after reset
//   draw_ack             1-cycle pulse: frame swapped in, draw the next one
//   vblank               vertical blank level from VGA timing
//   read_addr/read_data  scan-out read port, 1-cycle latency
//   front_sel            bank currently on screen
//   frame_count          completed swaps, wrapping
//   missed_vblank_count  vblank edges with no frame ready, saturating
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | idle cycle after reset release
// START    | request the first frame (draw_start next cycle)
// DRAWING  | drawer filling the back bank
// WAIT_VBL | frame complete, holding it until the next vblank edge
// SWAP     | flip banks, count the frame, ack the drawer
// ACK_WAIT | back bank writable, waiting for the drawer to drop frame_done
module frame_buffer_swapper
    import frame_buffer_swapper_pkg::*;
#(
    parameter int BUFFER_WIDTH      = FB_WIDTH,
    parameter int BUFFER_HEIGHT     = FB_HEIGHT,
    parameter int BUFFER_DATA_WIDTH = FB_DATA_W,
    parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
    parameter int MISS_CNT_WIDTH    = FB_MISS_W
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         fb_write_en,
    input  logic [BUFFER_ADDR_WIDTH-1:0] fb_write_addr,
    input  logic [BUFFER_DATA_WIDTH-1:0] fb_write_data,
    input  logic                         frame_done,
    output logic                         draw_start,
    output logic                         draw_ack,
    input  logic                         vblank,
    input  logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
    output logic [BUFFER_DATA_WIDTH-1:0] read_data,
    output logic                         front_sel,
    output logic [FB_FRAME_W-1:0]        frame_count,
    output logic [MISS_CNT_WIDTH-1:0]    missed_vblank_count
);

    localparam int NPIX = BUFFER_WIDTH * BUFFER_HEIGHT;
    // One extra bit so the bound still fits when NPIX is a power of two.
    localparam logic [BUFFER_ADDR_WIDTH:0] NPIX_EXT = (BUFFER_ADDR_WIDTH + 1)'(NPIX);

    fb_state_t                      state_q, state_d;
    logic                           vblank_q, vblank_d;
    logic                           front_sel_q, front_sel_d;
    logic                           draw_start_q, draw_start_d;
    logic                           draw_ack_q, draw_ack_d;
    logic [FB_FRAME_W-1:0]          frame_count_q, frame_count_d;
    logic [MISS_CNT_WIDTH-1:0]      miss_q, miss_d;
    logic                           rd_sel_q, rd_sel_d;
    logic                           rd_valid_q, rd_valid_d;

    logic                           vblank_rise;
    logic                           wr_in_range;
    logic                           rd_in_range;
    logic                           wr_window;
    logic                           wr_accept;
    logic                           bank0_we;
    logic                           bank1_we;
    logic [BUFFER_ADDR_WIDTH-1:0]   rd_addr_safe;
    logic [BUFFER_DATA_WIDTH-1:0]   bank0_rd;
    logic [BUFFER_DATA_WIDTH-1:0]   bank1_rd;

    assign vblank_rise = vblank & ~vblank_q;
    assign wr_in_range = {1'b0, fb_write_addr} < NPIX_EXT;
    assign rd_in_range = {1'b0, read_addr} < NPIX_EXT;

    // The drawer may start the next frame right after the ack, before it
    // has dropped frame_done, so ACK_WAIT accepts writes as well.
    assign wr_window = (state_q == DRAWING) || (state_q == ACK_WAIT);
    assign wr_accept = fb_write_en & wr_window & wr_in_range;

    // Writes go to the bank that is not on screen.
    assign bank0_we = wr_accept &  front_sel_q;
    assign bank1_we = wr_accept & ~front_sel_q;

    assign rd_addr_safe = rd_in_range ? read_addr : '0;

    fb_bank_ram #(
        .DATA_WIDTH (BUFFER_DATA_WIDTH),
        .ADDR_WIDTH (BUFFER_ADDR_WIDTH),
        .DEPTH      (NPIX)
    ) u_bank0 (
        .clk     (clk),
        .wr_en   (bank0_we),
        .wr_addr (fb_write_addr),
        .wr_data (fb_write_data),
        .rd_addr (rd_addr_safe),
        .rd_data (bank0_rd)
    );

    fb_bank_ram #(
        .DATA_WIDTH (BUFFER_DATA_WIDTH),
        .ADDR_WIDTH (BUFFER_ADDR_WIDTH),
        .DEPTH      (NPIX)
    ) u_bank1 (
        .clk     (clk),
        .wr_en   (bank1_we),
        .wr_addr (fb_write_addr),
        .wr_data (fb_write_data),
        .rd_addr (rd_addr_safe),
        .rd_data (bank1_rd)
    );

    always_comb begin
        state_d       = state_q;
        vblank_d      = vblank;
        front_sel_d   = front_sel_q;
        draw_start_d  = 1'b0;
        draw_ack_d    = 1'b0;
        frame_count_d = frame_count_q;
        miss_d        = miss_q;
        // Bank select travels with the address so a read issued during SWAP
        // still returns the bank that was on screen when it was issued.
        rd_sel_d      = front_sel_q;
        rd_valid_d    = rd_in_range;

        case (state_q)
            INIT: begin
                state_d = START;
            end
            START: begin
                draw_start_d = 1'b1;
                state_d      = DRAWING;
            end
            DRAWING: begin
                if (frame_done && vblank_rise) begin
                    state_d = SWAP;
                end else if (frame_done) begin
                    state_d = WAIT_VBL;
                end else if (vblank_rise && (miss_q != '1)) begin
                    miss_d = miss_q + MISS_CNT_WIDTH'(1);
                end
            end
            WAIT_VBL: begin
                if (vblank_rise) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                front_sel_d   = ~front_sel_q;
                frame_count_d = frame_count_q + FB_FRAME_W'(1);
                draw_ack_d    = 1'b1;
                state_d       = ACK_WAIT;
            end
            ACK_WAIT: begin
                // frame_done is still high from the frame just accepted;
                // wait for it to drop so it is not taken as a new frame.
                if (!frame_done) begin
                    state_d = DRAWING;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= INIT;
            vblank_q      <= 1'b0;
            front_sel_q   <= 1'b0;
            draw_start_q  <= 1'b0;
            draw_ack_q    <= 1'b0;
            frame_count_q <= '0;
            miss_q        <= '0;
            rd_sel_q      <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            vblank_q      <= vblank_d;
            front_sel_q   <= front_sel_d;
            draw_start_q  <= draw_start_d;
            draw_ack_q    <= draw_ack_d;
            frame_count_q <= frame_count_d;
            miss_q        <= miss_d;
            rd_sel_q      <= rd_sel_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    // rd_valid_q clears on reset and for out-of-range addresses, which
    // forces read_data to zero without resetting the RAM read registers.
    assign read_data           = rd_valid_q ? (rd_sel_q ? bank1_rd : bank0_rd) : '0;
    assign draw_start          = draw_start_q;
    assign draw_ack            = draw_ack_q;
    assign front_sel           = front_sel_q;
    assign frame_count         = frame_count_q;
    assign missed_vblank_count = miss_q;

endmodule

// File: tb/tb_frame_buffer_swapper.sv
// Self-checking bench for frame_buffer_swapper: directed protocol steps with
// random pixel traffic, checked against a two-bank memory model and simple
// frame/miss counters kept in the bench.
module tb_frame_buffer_swapper;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;
    localparam int AW   = 15;
    localparam int DW   = 12;

    logic            clk = 1'b0;
    logic            rstn;
    logic            fb_write_en;
    logic [AW-1:0]   fb_write_addr;
    logic [DW-1:0]   fb_write_data;
    logic            frame_done;
    logic            draw_start;
    logic            draw_ack;
    logic            vblank;
    logic [AW-1:0]   read_addr;
    logic [DW-1:0]   read_data;
    logic            front_sel;
    logic [15:0]     frame_count;
    logic [15:0]     missed_vblank_count;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [DW-1:0] m_bank [2][NPIX];
    int            m_front;
    int            m_frames;
    int            m_miss;
    int            wq[$];

    always #5 clk = ~clk;

    frame_buffer_swapper dut (
        .clk                 (clk),
        .rstn                (rstn),
        .fb_write_en         (fb_write_en),
        .fb_write_addr       (fb_write_addr),
        .fb_write_data       (fb_write_data),
        .frame_done          (frame_done),
        .draw_start          (draw_start),
        .draw_ack            (draw_ack),
        .vblank              (vblank),
        .read_addr           (read_addr),
        .read_data           (read_data),
        .front_sel           (front_sel),
        .frame_count         (frame_count),
        .missed_vblank_count (missed_vblank_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_px(input int a, input logic [DW-1:0] d);
        fb_write_en   = 1'b1;
        fb_write_addr = AW'(a);
        fb_write_data = d;
        tick();
        fb_write_en   = 1'b0;
    endtask

    // Random frame content into the back bank, recorded in the model.
    task automatic draw_writes(input int n);
        int a;
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(16, NPIX - 1));
            d = DW'($urandom_range(0, 4095));
            write_px(a, d);
            m_bank[1 - m_front][a] = d;
            wq.push_back(a);
        end
    endtask

    task automatic read_check(input string tag, input int a);
        logic [DW-1:0] exp;
        read_addr = AW'(a);
        tick();
        exp = (a < NPIX) ? m_bank[m_front][a] : '0;
        chk(tag, read_data, exp);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_front"}, front_sel, m_front);
        chk({tag, "_frames"}, frame_count, m_frames & 16'hFFFF);
        chk({tag, "_miss"}, missed_vblank_count, (m_miss > 16'hFFFF) ? 16'hFFFF : m_miss);
    endtask

    task automatic reset_expect(input string tag);
        m_front  = 0;
        m_frames = 0;
        m_miss   = 0;
        check_counters(tag);
        chk({tag, "_rdata"}, read_data, 0);
        chk({tag, "_start"}, draw_start, 0);
        chk({tag, "_ack"}, draw_ack, 0);
    endtask

    // Draw start follows reset release after two clock edges.
    task automatic start_expect(input string tag);
        tick();
        chk({tag, "_start_e1"}, draw_start, 0);
        tick();
        chk({tag, "_start_e2"}, draw_start, 1);
        tick();
        chk({tag, "_start_e3"}, draw_start, 0);
    endtask

    initial begin
        int found;
        int extra_acks;
        int n;

        rstn          = 1'b0;
        fb_write_en   = 1'b0;
        fb_write_addr = '0;
        fb_write_data = '0;
        frame_done    = 1'b0;
        vblank        = 1'b0;
        read_addr     = '0;

        // 1: reset state and first draw_start
        tick();
        tick();
        reset_expect("rst");
        rstn = 1'b1;
        start_expect("rst");

        // 2 + 3: first frame, swap on vblank, single ack under held frame_done
        write_px(5, 12'hF00);
        m_bank[1 - m_front][5] = 12'hF00;
        draw_writes(int'($urandom_range(24, 48)));
        frame_done = 1'b1;
        n = int'($urandom_range(1, 4));
        for (int i = 0; i < n; i++) tick();
        chk("f1_no_early_ack", draw_ack, 0);
        vblank = 1'b1;
        found  = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (draw_ack) found = 1;
        end
        chk("f1_ack_seen", found, 1);
        m_front  = 1 - m_front;
        m_frames++;
        check_counters("f1");
        extra_acks = 0;
        vblank     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            // A write while waiting for frame_done to drop is accepted.
            if (i == 3) begin
                fb_write_en   = 1'b1;
                fb_write_addr = AW'(7);
                fb_write_data = 12'h123;
            end
            if (i == 4) fb_write_en = 1'b0;
            tick();
            if (draw_ack) extra_acks++;
        end
        m_bank[1 - m_front][7] = 12'h123;
        chk("f1_single_ack", extra_acks, 0);
        chk("f1_front_held", front_sel, m_front);
        read_check("f1_rd5", 5);
        foreach (wq[i]) read_check("f1_rd", wq[i]);
        frame_done = 1'b0;
        tick();

        // 4: missed vblanks, then frame_done and vblank rise together
        wq.delete();
        write_px(5, 12'h0A5);
        m_bank[1 - m_front][5] = 12'h0A5;
        draw_writes(int'($urandom_range(24, 48)));
        for (int k = 0; k < 3; k++) begin
            vblank = 1'b1;
            tick();
            m_miss++;
            vblank = 1'b0;
            n = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) tick();
        end
        check_counters("miss3");
        frame_done = 1'b1;
        vblank     = 1'b1;
        tick();
        chk("same_cycle_ack_e1", draw_ack, 0);
        tick();
        chk("same_cycle_ack_e2", draw_ack, 1);
        m_front  = 1 - m_front;
        m_frames++;
        check_counters("f2");
        frame_done = 1'b0;
        vblank     = 1'b0;
        read_check("f2_rd5", 5);
        read_check("f2_rd7_ackwait", 7);
        foreach (wq[i]) read_check("f2_rd", wq[i]);

        // 5: out-of-range write, writes dropped in WAIT_VBL, read at swap
        wq.delete();
        draw_writes(int'($urandom_range(24, 48)));
        write_px(NPIX, 12'hABC);
        frame_done = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) write_px(wq[i], m_bank[1 - m_front][wq[i]] ^ 12'hFFF);
        write_px(5, 12'h777);
        read_addr = AW'(5);
        vblank    = 1'b1;
        tick();
        chk("swap_rd_pre", read_data, m_bank[m_front][5]);
        tick();
        chk("swap_ack", draw_ack, 1);
        chk("swap_front", front_sel, 1 - m_front);
        chk("swap_rd_old_bank", read_data, m_bank[m_front][5]);
        m_front  = 1 - m_front;
        m_frames++;
        tick();
        chk("swap_rd_new_bank", read_data, m_bank[m_front][5]);
        frame_done = 1'b0;
        vblank     = 1'b0;
        check_counters("f3");
        foreach (wq[i]) read_check("f3_rd", wq[i]);
        read_check("rd_oob_19200", NPIX);
        read_check("rd_oob_max", 32767);

        // 6: reset mid-frame
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        reset_expect("rst2");
        start_expect("rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
